// File: rtl/layer_pkg.sv
// Shared definitions for the layer_* stream blocks: argmax FSM states and
// the valid/ready handshake helper.
package layer_pkg;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_OUT     = 1'b1
    } argmax_state_t;

    localparam logic HS_IDLE = 1'b0;
    localparam logic HS_XFER = 1'b1;

    function automatic logic handshake(input logic valid, input logic ready);
        return (valid && ready) ? HS_XFER : HS_IDLE;
    endfunction

endpackage

// File: rtl/layer_argmax_if.sv
// Word stream in (from the final layer) and classification result out.
interface layer_argmax_if #(
    parameter int M    = 4,
    parameter int T    = 16,
    parameter int LOGM = $clog2(M + 1)
);
    logic                   s_valid;
    logic                   s_ready;
    logic signed [T-1:0]    data_in;
    logic                   m_valid;
    logic                   m_ready;
    logic        [LOGM-1:0] data_out;
    logic signed [T-1:0]    max_out;

    // The argmax block itself is the slave; the stream source/result sink is the master.
    modport slave (
        input  s_valid, data_in, m_ready,
        output s_ready, m_valid, data_out, max_out
    );

    modport master (
        output s_valid, data_in, m_ready,
        input  s_ready, m_valid, data_out, max_out
    );
endinterface

// File: rtl/layer_argmax.sv
// Consumes one M-word signed vector and reports the index and value of its
// maximum element (lowest index wins on ties).
module layer_argmax
    import layer_pkg::*;
#(
    parameter int M    = 4,
    parameter int T    = 16,
    parameter int LOGM = $clog2(M + 1)
) (
    input  logic           clk,
    input  logic           reset,
    layer_argmax_if.slave  bus
);

    localparam logic [LOGM-1:0] LAST = LOGM'(M - 1);

    argmax_state_t          state;
    logic        [LOGM-1:0] count;
    logic signed [T-1:0]    max_val;
    logic        [LOGM-1:0] index;
    logic                   m_valid_r;
    logic                   s_ready_c;

    // Decoded from registered state only, so m_ready never reaches s_ready.
    assign s_ready_c    = (state == S_COLLECT) && reset;
    assign bus.s_ready  = s_ready_c;
    assign bus.m_valid  = m_valid_r;
    assign bus.data_out = index;
    assign bus.max_out  = max_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_COLLECT;
            count     <= '0;
            max_val   <= '0;
            index     <= '0;
            m_valid_r <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values of count and max_val, whatever the statement order.
            case (state)
                S_COLLECT: begin
                    if (handshake(bus.s_valid, s_ready_c) == HS_XFER) begin
                        if (count == '0 || bus.data_in > max_val) begin
                            max_val <= bus.data_in;
                            index   <= count;
                        end
                        if (count == LAST) begin
                            count     <= '0;
                            state     <= S_OUT;
                            m_valid_r <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (handshake(m_valid_r, bus.m_ready) == HS_XFER) begin
                        m_valid_r <= 1'b0;
                        state     <= S_COLLECT;
                    end
                end
                default: begin
                    state     <= S_COLLECT;
                    m_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_argmax.sv
// Randomised and directed stimulus for layer_argmax, checked every cycle
// against a vector-level argmax model.
module tb_layer_argmax;

    localparam int M    = 4;
    localparam int T    = 16;
    localparam int LOGM = $clog2(M + 1);

    logic clk;
    logic reset;
    bit   rand_mr;

    int checks;
    int errors;

    int words[$];
    bit have_res;
    int res_idx;
    int res_max;
    int hs_idx_q[$];
    int hs_max_q[$];

    layer_argmax_if #(.M(M), .T(T), .LOGM(LOGM)) bus ();

    layer_argmax #(.M(M), .T(T), .LOGM(LOGM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: first position holding the largest signed value.
    function automatic void argmax_of(input int v[$], output int idx, output int mx);
        idx = 0;
        for (int i = 1; i < v.size(); i++)
            if (v[i] > v[idx]) idx = i;
        mx = v[idx];
    endfunction

    // Model + compare, sampled on the falling edge where all signals are stable.
    always @(negedge clk) begin
        if (!reset) begin
            words.delete();
            have_res = 1'b0;
            check("rst_s_ready", int'(bus.s_ready), 0);
            check("rst_m_valid", int'(bus.m_valid), 0);
        end else begin
            check("s_ready", int'(bus.s_ready), int'(!have_res));
            check("m_valid", int'(bus.m_valid), int'(have_res));
            if (have_res) begin
                check("data_out", int'(bus.data_out), res_idx);
                check("max_out", int'(bus.max_out), res_max);
                if (bus.m_ready) begin
                    hs_idx_q.push_back(int'(bus.data_out));
                    hs_max_q.push_back(int'(bus.max_out));
                    have_res = 1'b0;
                end
            end else if (bus.s_valid) begin
                words.push_back(int'(bus.data_in));
                if (words.size() == M) begin
                    argmax_of(words, res_idx, res_max);
                    have_res = 1'b1;
                    words.delete();
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mr) bus.m_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Called and returns at posedge+1.
    task automatic put_word(input int w, input int max_idle);
        bit ok;
        bus.s_valid = 1'b0;
        repeat ($urandom_range(0, max_idle)) begin
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b1;
        bus.data_in = T'(w);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                bus.s_valid = 1'b0;
                return;
            end
        end
        bus.s_valid = 1'b0;
        check("put_word_timeout", 0, 1);
    endtask

    task automatic run_vec(input int a, input int b, input int c, input int d, input int max_idle);
        put_word(a, max_idle);
        put_word(b, max_idle);
        put_word(c, max_idle);
        put_word(d, max_idle);
    endtask

    task automatic wait_hs(input int n);
        for (int i = 0; i < 300; i++) begin
            if (hs_idx_q.size() >= n) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("wait_hs_timeout", hs_idx_q.size(), n);
    endtask

    task automatic expect_res(input string name, input int pos, input int idx, input int mx);
        if (pos >= hs_idx_q.size()) begin
            check({name, "_missing"}, hs_idx_q.size(), pos + 1);
            return;
        end
        check({name, "_idx"}, hs_idx_q[pos], idx);
        check({name, "_max"}, hs_max_q[pos], mx);
    endtask

    initial begin
        int base;
        int v[4];
        int hold_idx;
        int hold_max;
        bus.s_valid = 1'b0;
        bus.data_in = '0;
        bus.m_ready = 1'b1;
        rand_mr     = 1'b0;
        reset       = 1'b0;
        #12;
        check("reset_m_valid", int'(bus.m_valid), 0);
        check("reset_s_ready", int'(bus.s_ready), 0);
        check("reset_data_out", int'(bus.data_out), 0);
        check("reset_max_out", int'(bus.max_out), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_s_ready", int'(bus.s_ready), 1);

        base = hs_idx_q.size();
        run_vec(0, 37, 12, 5, 0);
        wait_hs(base + 1);
        expect_res("basic", base, 1, 37);

        base = hs_idx_q.size();
        run_vec(-5, -3, -9, -3, 0);
        run_vec(0, 0, 0, 0, 0);
        run_vec(1, 2, 3, 32767, 0);
        run_vec(-32768, -32768, -32768, -32767, 0);
        run_vec(10, 9, 8, 7, 0);
        wait_hs(base + 5);
        expect_res("tie_neg", base, 1, -3);
        expect_res("zeros", base + 1, 0, 0);
        expect_res("last_max", base + 2, 3, 32767);
        expect_res("min_vals", base + 3, 3, -32767);
        expect_res("first_max", base + 4, 0, 10);

        // Backpressure: result held, extra word offered but refused.
        base = hs_idx_q.size();
        bus.m_ready = 1'b0;
        run_vec(5, -2, 11, 4, 0);
        bus.s_valid = 1'b1;
        bus.data_in = T'(99);
        @(negedge clk);
        hold_idx = int'(bus.data_out);
        hold_max = int'(bus.max_out);
        check("bp_idx", hold_idx, 2);
        check("bp_max", hold_max, 11);
        repeat (5) begin
            @(negedge clk);
            check("bp_stable_idx", int'(bus.data_out), hold_idx);
            check("bp_stable_max", int'(bus.max_out), hold_max);
            check("bp_s_ready", int'(bus.s_ready), 0);
            check("bp_m_valid", int'(bus.m_valid), 1);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        wait_hs(base + 1);
        expect_res("bp", base, 2, 11);
        check("bp_count", hs_idx_q.size(), base + 1);
        @(negedge clk);
        check("bp_s_ready_back", int'(bus.s_ready), 1);
        @(posedge clk);
        #1;

        base = hs_idx_q.size();
        run_vec(3, 8, 1, 2, 3);
        run_vec(4, 4, 9, 0, 3);
        wait_hs(base + 2);
        expect_res("gap_a", base, 1, 8);
        expect_res("gap_b", base + 1, 2, 9);

        // Asynchronous reset in the middle of a vector.
        put_word(50, 0);
        put_word(60, 0);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_m_valid", int'(bus.m_valid), 0);
        check("async_rst_s_ready", int'(bus.s_ready), 0);
        #13;
        reset = 1'b1;
        @(posedge clk);
        #1;
        base = hs_idx_q.size();
        run_vec(6, 1, 7, 2, 0);
        wait_hs(base + 1);
        expect_res("after_rst", base, 2, 7);

        // Random vectors, random gaps, random backpressure.
        base = hs_idx_q.size();
        rand_mr = 1'b1;
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0)
                    v[i] = (k % 2 == 0) ? -1 : 7;
                else
                    v[i] = int'($signed(16'($urandom())));
            end
            run_vec(v[0], v[1], v[2], v[3], 2);
        end
        rand_mr = 1'b0;
        bus.m_ready = 1'b1;
        wait_hs(base + 25);
        check("rand_count", hs_idx_q.size(), base + 25);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
